sprite_palette_ctrl: RTL and testbench

//  Banked, run-time-loadable sprite palette with its load controller.

---
 rtl/sprite_palette_pkg.sv | 32 +++
 rtl/sprite_palette_load_fsm.sv | 72 +++++++
 rtl/sprite_palette_ctrl.sv | 102 ++++++++++
 tb/tb_sprite_palette_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_palette_pkg.sv
// Shared types and defaults for the banked sprite palette and its load controller.
// The optional output dimming stage is enabled with PALETTE_FADE_EN.
package sprite_palette_pkg;

  localparam int PAL_NUM_BANKS = 4;
  localparam int PAL_ENTRIES   = 16;
  localparam int PAL_COLOR_W   = 4;
  localparam int PAL_RGB_W     = 3 * PAL_COLOR_W;

  typedef struct packed {
    logic [PAL_COLOR_W-1:0] r;
    logic [PAL_COLOR_W-1:0] g;
    logic [PAL_COLOR_W-1:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BLANK,
    LOAD,
    DONE
  } pal_state_e;

  // Dimming shifts each channel right by the fade level; level 0 passes the colour through.
  function automatic rgb_t fade_rgb(input rgb_t c, input logic [1:0] lvl);
    rgb_t o;
    o.r = c.r >> lvl;
    o.g = c.g >> lvl;
    o.b = c.b >> lvl;
    return o;
  endfunction

endpackage

// File: rtl/sprite_palette_load_fsm.sv
// Load controller: waits for vertical blank, then streams ENTRIES words into one latched bank.
// A load interrupted by the end of blanking resumes at the same entry on the next blank.
module sprite_palette_load_fsm
  import sprite_palette_pkg::*;
#(
  parameter int ENTRIES = PAL_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int BANK_W  = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              vblank,
  input  logic              load_req,
  input  logic [BANK_W-1:0] load_bank,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic              busy,
  output logic              load_done,
  output logic              wr_en,
  output logic [BANK_W-1:0] wr_bank,
  output logic [IDX_W-1:0]  wr_idx,
  output pal_state_e        state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

  logic [IDX_W-1:0]  cnt;
  logic [BANK_W-1:0] bank;

  // Stream handshake: a word transfers on a cycle where wr_valid and wr_ready are both 1.
  // wr_ready only rises in LOAD during blanking, so a word offered as vblank falls is held back.
  assign wr_ready  = (state == LOAD) && vblank;
  assign wr_en     = wr_valid && wr_ready;
  assign busy      = (state != IDLE);
  assign load_done = (state == DONE);
  assign wr_bank   = bank;
  assign wr_idx    = cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      bank  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_req) begin
            bank  <= load_bank;
            cnt   <= '0;
            state <= WAIT_BLANK;
          end
        end
        WAIT_BLANK: begin
          if (vblank) state <= LOAD;
        end
        LOAD: begin
          if (wr_en) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST_IDX) state <= DONE;
          end else if (!vblank) begin
            state <= WAIT_BLANK;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sprite_palette_ctrl.sv
// Banked sprite palette: one-cycle registered lookup plus a blank-synchronised reload port.
// Defining PALETTE_FADE_EN adds the fade_level input that dims the looked-up colour.
module sprite_palette_ctrl
  import sprite_palette_pkg::*;
#(
  parameter int NUM_BANKS = PAL_NUM_BANKS,
  parameter int ENTRIES   = PAL_ENTRIES,
  parameter int IDX_W     = $clog2(ENTRIES),
  parameter int BANK_W    = $clog2(NUM_BANKS)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   vblank,
  input  logic                   pix_valid,
  input  logic [BANK_W-1:0]      pix_bank,
  input  logic [IDX_W-1:0]       pix_index,
  output logic                   pix_rgb_valid,
  output logic [PAL_COLOR_W-1:0] red,
  output logic [PAL_COLOR_W-1:0] green,
  output logic [PAL_COLOR_W-1:0] blue,
  input  logic                   load_req,
  input  logic [BANK_W-1:0]      load_bank,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [PAL_RGB_W-1:0]   wr_data,
  output logic                   busy,
  output logic                   load_done,
  output pal_state_e             dbg_state
`ifdef PALETTE_FADE_EN
  ,
  input  logic [1:0]             fade_level
`endif
);

  localparam int DEPTH = NUM_BANKS * ENTRIES;

  rgb_t              mem [DEPTH];
  rgb_t              rd_entry;
  rgb_t              rd_shown;
  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [IDX_W-1:0]  wr_idx;

  sprite_palette_load_fsm #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .BANK_W  (BANK_W)
  ) u_load_fsm (
    .Clk       (Clk),
    .Reset     (Reset),
    .vblank    (vblank),
    .load_req  (load_req),
    .load_bank (load_bank),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .load_done (load_done),
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_idx    (wr_idx),
    .state     (dbg_state)
  );

  // Storage is cleared on reset so an aborted load never leaves a partial bank behind.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[{wr_bank, wr_idx}] <= rgb_t'(wr_data);
    end
  end

  assign rd_entry = mem[{pix_bank, pix_index}];

`ifdef PALETTE_FADE_EN
  assign rd_shown = fade_rgb(rd_entry, fade_level);
`else
  assign rd_shown = rd_entry;
`endif

  // The read samples the array before this edge's write lands, so a colliding read sees the old colour.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pix_rgb_valid <= 1'b0;
      red           <= '0;
      green         <= '0;
      blue          <= '0;
    end else begin
      pix_rgb_valid <= pix_valid;
      if (pix_valid) begin
        red   <= rd_shown.r;
        green <= rd_shown.g;
        blue  <= rd_shown.b;
      end else begin
        red   <= '0;
        green <= '0;
        blue  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_palette_ctrl.sv
// Directed bench for sprite_palette_ctrl: pixel reads are scoreboarded through exp_q,
// control outputs are checked in-line. Defining PALETTE_FADE_EN also exercises fade_level.
module tb_sprite_palette_ctrl;
  import sprite_palette_pkg::*;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        vblank = 1'b0;
  logic        pix_valid = 1'b0;
  logic [1:0]  pix_bank = '0;
  logic [3:0]  pix_index = '0;
  logic        pix_rgb_valid;
  logic [3:0]  red, green, blue;
  logic        load_req = 1'b0;
  logic [1:0]  load_bank = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [11:0] wr_data = '0;
  logic        busy;
  logic        load_done;
  pal_state_e  dbg_state;
`ifdef PALETTE_FADE_EN
  logic [1:0]  fade_level = 2'd0;
`endif

  logic [11:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;

  sprite_palette_ctrl dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .vblank        (vblank),
    .pix_valid     (pix_valid),
    .pix_bank      (pix_bank),
    .pix_index     (pix_index),
    .pix_rgb_valid (pix_rgb_valid),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .load_req      (load_req),
    .load_bank     (load_bank),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_data       (wr_data),
    .busy          (busy),
    .load_done     (load_done),
    .dbg_state     (dbg_state)
`ifdef PALETTE_FADE_EN
    ,
    .fade_level    (fade_level)
`endif
  );

  // clock / reset
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge Clk) begin
    if (mon_en) begin
      if (pix_rgb_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pixel", 32'd1, 32'd0);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check("pixel_rgb", {20'd0, red, green, blue}, {20'd0, e});
        end
      end else begin
        check("idle_rgb_zero", {20'd0, red, green, blue}, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic read_px(input logic [1:0] b, input logic [3:0] i, input logic [11:0] e);
    pix_valid = 1'b1;
    pix_bank  = b;
    pix_index = i;
    exp_q.push_back(e);
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic start_load(input logic [1:0] b);
    load_req  = 1'b1;
    load_bank = b;
    tick();
    load_req  = 1'b0;
  endtask

  task automatic push_word(input logic [11:0] d);
    bit done;
    done     = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge Clk);
      if (wr_ready === 1'b1) done = 1'b1;
      tick();
    end
    if (!done) check("handshake_timeout", 32'd0, 32'd1);
    wr_valid = 1'b0;
  endtask

  function automatic logic [11:0] t2_word(input int i);
    case (i)
      0:       return 12'h2C6;
      3:       return 12'hE43;
      15:      return 12'h2C7;
      default: return 12'h100 | 12'(i);
    endcase
  endfunction

  initial begin
    // 1: reset state and first lookup
    repeat (2) @(posedge Clk);
    #1;
    Reset  = 1'b0;
    mon_en = 1'b1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
    check("reset_load_done", {31'd0, load_done}, 32'd0);
    check("reset_rgb_valid", {31'd0, pix_rgb_valid}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    read_px(2'd0, 4'd5, 12'h000);

    // 2: full load of bank 1 during blanking
    vblank = 1'b1;
    start_load(2'd1);
    check("wait_blank_busy", {31'd0, busy}, 32'd1);
    check("wait_blank_no_ready", {31'd0, wr_ready}, 32'd0);
    for (int i = 0; i < 16; i++) push_word(t2_word(i));
    check("t2_load_done", {31'd0, load_done}, 32'd1);
    tick();
    check("t2_done_pulse_end", {31'd0, load_done}, 32'd0);
    check("t2_idle_busy", {31'd0, busy}, 32'd0);
    read_px(2'd1, 4'd0, 12'h2C6);
    read_px(2'd1, 4'd15, 12'h2C7);

    // 3: blanking ends mid-load of bank 2, then resumes
    start_load(2'd2);
    for (int i = 0; i < 5; i++) push_word(12'h300 | 12'(i));
    vblank = 1'b0;
    #1;
    check("t3_ready_drop", {31'd0, wr_ready}, 32'd0);
    check("t3_busy_hold", {31'd0, busy}, 32'd1);
    wr_valid = 1'b1;
    wr_data  = 12'h305;
    repeat (3) tick();
    check("t3_paused_ready", {31'd0, wr_ready}, 32'd0);
    check("t3_paused_state", 32'(dbg_state), 32'(WAIT_BLANK));
    vblank = 1'b1;
    for (int i = 5; i < 16; i++) push_word(12'h300 | 12'(i));
    check("t3_load_done", {31'd0, load_done}, 32'd1);
    tick();
    read_px(2'd2, 4'd4, 12'h304);
    read_px(2'd2, 4'd5, 12'h305);
    read_px(2'd2, 4'd6, 12'h306);
    read_px(2'd2, 4'd15, 12'h30F);
    read_px(2'd1, 4'd3, 12'hE43);

    // 4: read of an entry in the same cycle it is rewritten
    start_load(2'd1);
    for (int i = 0; i < 3; i++) push_word(12'h400 | 12'(i));
    pix_valid = 1'b1;
    pix_bank  = 2'd1;
    pix_index = 4'd3;
    exp_q.push_back(12'hE43);
    push_word(12'hFFF);
    read_px(2'd1, 4'd3, 12'hFFF);
    for (int i = 4; i < 16; i++) push_word(12'h400 | 12'(i));
    check("t4_load_done", {31'd0, load_done}, 32'd1);
    tick();
    read_px(2'd1, 4'd0, 12'h400);
    read_px(2'd1, 4'd15, 12'h40F);

    // 5: reset in the middle of a load
    start_load(2'd3);
    for (int i = 0; i < 8; i++) push_word(12'h5A0 | 12'(i));
    check("t5_mid_busy", {31'd0, busy}, 32'd1);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("t5_reset_busy", {31'd0, busy}, 32'd0);
    check("t5_reset_ready", {31'd0, wr_ready}, 32'd0);
    check("t5_reset_state", 32'(dbg_state), 32'(IDLE));
    read_px(2'd3, 4'd0, 12'h000);
    read_px(2'd1, 4'd3, 12'h000);
    read_px(2'd2, 4'd5, 12'h000);
    start_load(2'd0);
    check("t5_new_load_busy", {31'd0, busy}, 32'd1);
    check("t5_new_load_state", 32'(dbg_state), 32'(WAIT_BLANK));
    load_req  = 1'b1;
    load_bank = 2'd3;
    tick();
    load_req  = 1'b0;

    // 6: fill bank 0 with white, then look it up (dimmed when fading is built in)
    for (int i = 0; i < 16; i++) push_word(12'hFFF);
    check("t6_load_done", {31'd0, load_done}, 32'd1);
    tick();
    read_px(2'd3, 4'd0, 12'h000);
`ifdef PALETTE_FADE_EN
    fade_level = 2'd2;
    read_px(2'd0, 4'd7, 12'h333);
    fade_level = 2'd1;
    read_px(2'd0, 4'd7, 12'h777);
    fade_level = 2'd0;
    read_px(2'd0, 4'd7, 12'hFFF);
`else
    read_px(2'd0, 4'd7, 12'hFFF);
`endif

    // report
    vblank = 1'b0;
    repeat (3) tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
